// File: rtl/jk_reg_bank.sv
// Multi-mode register bank built from WIDTH JK cells.
// Modes: JK bank, up counter, down counter, serial shift-left.
module jk_reg_bank #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             changed
);

  localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

  localparam logic [1:0] M_JK   = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DOWN = 2'b10;
  localparam logic [1:0] M_SHL  = 2'b11;

  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] cj;
  logic [WIDTH-1:0] ck;
  logic [WIDTH-1:0] q_nxt;
  logic             all_one;
  logic             all_zero;

  // Ripple toggle enables: a bit toggles when every lower bit is 1 (up) or 0 (down)
  always_comb begin
    t_up    = '0;
    t_dn    = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & q[i-1];
      t_dn[i] = t_dn[i-1] & ~q[i-1];
    end
  end

  assign shl      = {q[WIDTH-2:0], ser_in};
  assign all_one  = &q;
  assign all_zero = ~|q;

  // Select the J/K drive of every cell; shift mode sets or clears each bit
  always_comb begin
    cj = '0;
    ck = '0;
    unique case (mode)
      M_JK: begin
        cj = j;
        ck = k;
      end
      M_UP: begin
        cj = t_up;
        ck = t_up;
      end
      M_DOWN: begin
        cj = t_dn;
        ck = t_dn;
      end
      M_SHL: begin
        cj = shl;
        ck = ~shl;
      end
      default: begin
        cj = '0;
        ck = '0;
      end
    endcase
  end

  // Characteristic equation of a JK cell, applied bitwise
  always_comb begin
    q_nxt = (cj & ~q) | (~ck & q);
  end

  // Terminal count tracks mode combinationally
  always_comb begin
    tc = 1'b0;
    unique case (mode)
      M_UP:    tc = all_one;
      M_DOWN:  tc = all_zero;
      default: tc = 1'b0;
    endcase
  end

  // State and registered flags; reset wins, disabled edges clear the pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= RST_Q;
      wrap    <= 1'b0;
      changed <= 1'b0;
    end else if (!en) begin
      wrap    <= 1'b0;
      changed <= 1'b0;
    end else begin
      q       <= q_nxt;
      wrap    <= tc;
      changed <= (q_nxt != q);
    end
  end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Bench for jk_reg_bank: vector table, corner sequences,
// then random stimulus against a behavioural model.
module tb_jk_reg_bank;

  logic       clk;
  logic       rst_n;
  logic       rst5_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] j;
  logic [3:0] k;
  logic       ser_in;

  logic [3:0] q0;
  logic       tc0;
  logic       wrap0;
  logic       chg0;
  logic [3:0] q5;
  logic       tc5;
  logic       wrap5;
  logic       chg5;

  int n_cmp = 0;
  int n_bad = 0;

  jk_reg_bank #(.WIDTH(4), .RESET_VAL(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .j(j), .k(k), .ser_in(ser_in),
    .q(q0), .tc(tc0), .wrap(wrap0), .changed(chg0)
  );

  jk_reg_bank #(.WIDTH(4), .RESET_VAL(32'h5)) dut5 (
    .clk(clk), .rst_n(rst5_n), .en(en), .mode(mode),
    .j(j), .k(k), .ser_in(ser_in),
    .q(q5), .tc(tc5), .wrap(wrap5), .changed(chg5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic       ser;
    logic [3:0] eq;
    logic       ew;
    logic       ec;
    logic       et;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic r5, input logic e,
                      input logic [1:0] m, input logic [3:0] jj,
                      input logic [3:0] kk, input logic s);
    @(negedge clk);
    rst_n  = r;
    rst5_n = r5;
    en     = e;
    mode   = m;
    j      = jj;
    k      = kk;
    ser_in = s;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(logic r, logic e, logic [1:0] m,
                              logic [3:0] jj, logic [3:0] kk, logic s,
                              logic [3:0] eq, logic ew, logic ec,
                              logic et);
    vec_t v;
    v.rst_n = r; v.en = e; v.mode = m; v.j = jj; v.k = kk;
    v.ser = s; v.eq = eq; v.ew = ew; v.ec = ec; v.et = et;
    tbl.push_back(v);
  endfunction

  function automatic logic [3:0] ref_next(logic [3:0] cq, logic [1:0] m,
                                          logic [3:0] jj, logic [3:0] kk,
                                          logic s);
    logic [3:0] r;
    r = cq;
    case (m)
      2'd0: for (int i = 0; i < 4; i++) begin
        if (jj[i] && kk[i]) r[i] = !cq[i];
        else if (jj[i])     r[i] = 1'b1;
        else if (kk[i])     r[i] = 1'b0;
      end
      2'd1: r = 4'((int'(cq) + 1) % 16);
      2'd2: r = 4'((int'(cq) + 15) % 16);
      default: r = 4'((int'(cq) * 2 + int'(s)) % 16);
    endcase
    return r;
  endfunction

  function automatic logic ref_tc(logic [3:0] cq, logic [1:0] m);
    return (m == 2'd1 && cq == 4'd15) || (m == 2'd2 && cq == 4'd0);
  endfunction

  initial begin
    logic [3:0] mq[2];
    logic       mw[2];
    logic       mc[2];
    logic       rr[2];
    logic [3:0] nq;
    logic [3:0] rv[2];

    rst_n = 0; rst5_n = 0; en = 0; mode = 0;
    j = 0; k = 0; ser_in = 0;

    // JK truth table
    add(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    add(1, 1, 0, 4'b1010, 4'b0000, 0, 4'b1010, 0, 1, 0);
    add(1, 1, 0, 4'b0000, 4'b0000, 0, 4'b1010, 0, 0, 0);
    add(1, 1, 0, 4'b0000, 4'b0010, 0, 4'b1000, 0, 1, 0);
    add(1, 1, 0, 4'b1111, 4'b1111, 0, 4'b0111, 0, 1, 0);
    // Down count with enable gaps
    add(0, 1, 2, 0, 0, 0, 4'h0, 0, 0, 1);
    add(1, 1, 2, 0, 0, 0, 4'hF, 1, 1, 0);
    add(1, 0, 2, 0, 0, 0, 4'hF, 0, 0, 0);
    add(1, 0, 2, 4'hF, 4'hF, 1, 4'hF, 0, 0, 0);
    add(1, 0, 2, 0, 0, 0, 4'hF, 0, 0, 0);
    add(1, 1, 2, 4'h3, 4'h5, 1, 4'hE, 0, 1, 0);
    // Shift left
    add(0, 1, 3, 0, 0, 0, 4'h0, 0, 0, 0);
    add(1, 1, 3, 4'hF, 4'h0, 1, 4'b0001, 0, 1, 0);
    add(1, 1, 3, 4'hF, 4'h0, 0, 4'b0010, 0, 1, 0);
    add(1, 1, 3, 4'h0, 4'hF, 1, 4'b0101, 0, 1, 0);
    add(1, 1, 3, 4'h0, 4'h0, 1, 4'b1011, 0, 1, 0);
    add(1, 1, 3, 4'h0, 4'h0, 0, 4'b0110, 0, 1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, 1'b0, tbl[i].en, tbl[i].mode,
           tbl[i].j, tbl[i].k, tbl[i].ser);
      check($sformatf("vec%0d q", i), q0, tbl[i].eq);
      check($sformatf("vec%0d wrap", i), wrap0, tbl[i].ew);
      check($sformatf("vec%0d changed", i), chg0, tbl[i].ec);
      check($sformatf("vec%0d tc", i), tc0, tbl[i].et);
    end

    // Up count through rollover
    step(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, 1, 1, 4'hA, 4'h5, 0);
    check("up15 q", q0, 4'hF);
    check("up15 tc", tc0, 1);
    step(1, 0, 1, 1, 0, 0, 0);
    check("roll q", q0, 4'h0);
    check("roll wrap", wrap0, 1);
    check("roll tc", tc0, 0);
    step(1, 0, 1, 1, 0, 0, 0);
    check("post q", q0, 4'h1);
    check("post wrap", wrap0, 0);

    // Mode switch without an edge
    step(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, 1, 1, 0, 0, 0);
    check("sw tc up", tc0, 1);
    mode = 2'd2;
    #1;
    check("sw tc down", tc0, 0);
    step(1, 0, 1, 2, 0, 0, 0);
    check("sw q", q0, 4'hE);
    check("sw wrap", wrap0, 0);

    // Reset priority with RESET_VAL=5
    step(0, 0, 1, 1, 0, 0, 0);
    check("r5 q", q5, 4'h5);
    for (int i = 0; i < 7; i++) step(1, 1, 1, 1, 0, 0, 0);
    check("r5 count q", q5, 4'hC);
    step(1, 0, 1, 1, 0, 0, 0);
    check("r5 abort q", q5, 4'h5);
    check("r5 abort wrap", wrap5, 0);
    check("r5 abort chg", chg5, 0);
    step(1, 1, 1, 1, 0, 0, 0);
    check("r5 resume q", q5, 4'h6);
    step(1, 0, 0, 1, 0, 0, 0);
    check("r5 en0 q", q5, 4'h5);

    // Random stimulus against the reference model
    step(0, 0, 0, 0, 0, 0, 0);
    mq[0] = 4'h0; mq[1] = 4'h5;
    mw[0] = 0; mw[1] = 0; mc[0] = 0; mc[1] = 0;
    rv[0] = 4'h0; rv[1] = 4'h5;
    for (int n = 0; n < 400; n++) begin
      logic       e;
      logic [1:0] m;
      logic [3:0] jj;
      logic [3:0] kk;
      logic       s;
      rr[0] = ($urandom_range(0, 19) != 0);
      rr[1] = ($urandom_range(0, 19) != 0);
      e  = ($urandom_range(0, 4) != 0);
      m  = 2'($urandom_range(0, 3));
      jj = 4'($urandom);
      kk = 4'($urandom);
      s  = 1'($urandom);
      step(rr[0], rr[1], e, m, jj, kk, s);
      for (int d = 0; d < 2; d++) begin
        if (!rr[d]) begin
          mq[d] = rv[d]; mw[d] = 0; mc[d] = 0;
        end else if (!e) begin
          mw[d] = 0; mc[d] = 0;
        end else begin
          nq = ref_next(mq[d], m, jj, kk, s);
          mw[d] = (m == 2'd1 && mq[d] == 4'hF && nq == 4'h0) ||
                  (m == 2'd2 && mq[d] == 4'h0 && nq == 4'hF);
          mc[d] = (nq != mq[d]);
          mq[d] = nq;
        end
      end
      check("rnd q", q0, mq[0]);
      check("rnd wrap", wrap0, mw[0]);
      check("rnd changed", chg0, mc[0]);
      check("rnd tc", tc0, ref_tc(mq[0], m));
      check("rnd5 q", q5, mq[1]);
      check("rnd5 wrap", wrap5, mw[1]);
      check("rnd5 changed", chg5, mc[1]);
      check("rnd5 tc", tc5, ref_tc(mq[1], m));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
